// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// Optional overflow output is enabled by defining SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
   parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVF_EN
      , output ovf
`endif
   );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered two's-complement overflow flag.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic                clk,
   input logic                rst,
   serial_subtractor_if.slave bus
);

   localparam int            CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_nx;
   logic             load, busy_c, done_c, last_bit;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic [WIDTH-2:0] res_sr;
   logic [WIDTH-1:0] res_nx;
   logic             brw;
   logic [CW-1:0]    cnt;
   logic             cell_d, cell_bout;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;

   full_subtractor u_cell (
      .x    (a_sr[0]),
      .y    (b_sr[0]),
      .bin  (brw),
      .d    (cell_d),
      .bout (cell_bout)
   );

   assign last_bit = (cnt == LAST);
   // Bits already produced sit in res_sr; the current cell output completes the word.
   assign res_nx   = {cell_d, res_sr};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      busy_c   = 1'b0;
      done_c   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load     = 1'b1;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            busy_c = 1'b1;
            if (last_bit) state_nx = DONE;
         end
         DONE: begin
            done_c = 1'b1;
            if (bus.start) begin
               load     = 1'b1;
               state_nx = SHIFT;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         res_sr   <= '0;
         brw      <= 1'b0;
         cnt      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else if (load) begin
         a_sr <= bus.a;
         b_sr <= bus.b;
         brw  <= 1'b0;
         cnt  <= '0;
      end else if (state == SHIFT) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= res_nx[WIDTH-1:1];
         brw    <= cell_bout;
         cnt    <= cnt + 1'b1;
         if (last_bit) begin
            diff_q   <= res_nx;
            borrow_q <= cell_bout;
         end
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic ovf_q;

   // On the last bit the cell inputs are exactly the captured operand MSBs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (!load && state == SHIFT && last_bit) begin
         ovf_q <= (a_sr[0] != b_sr[0]) && (cell_d != a_sr[0]);
      end
   end

   assign bus.ovf = ovf_q;
`endif

   assign bus.busy       = busy_c;
   assign bus.done       = done_c;
   assign bus.diff       = diff_q;
   assign bus.borrow_out = borrow_q;

endmodule
